spi_adc_scanner: RTL and testbench

Parametrised SPI ADC front end for the PSU rail controllers. It generates `cs`/`sck` for one serial ADC and shifts in `NUM_CH` back-to-back conversion words per chip-select frame, each preceded by `LEAD_BITS` dummy bits. It presents all channel results together with a one-cycle valid strobe. It sits between each rail's ADC pins (`din_*`, `sck_*`, `cs_*`) and that rail's PID/error logic. It generalises the fixed 12-bit, two-word, five-lead-bit frame into configurable width, word count, lead bits and SCK rate.

---
 rtl/spi_adc_scanner.sv | 171 +++++++++++++++++
 tb/tb_spi_adc_scanner.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_adc_scanner.sv
// SPI ADC front end: runs cs/sck frames of NUM_CH words and presents all results with a one-cycle strobe.
// Define ADC_AVG_EN to report a per-channel moving average of the last 4 frames instead of raw words.
module spi_adc_scanner #(
    parameter int ADC_WIDTH = 12,
    parameter int NUM_CH    = 2,
    parameter int LEAD_BITS = 5,
    parameter int CLK_DIV   = 4,
    parameter int CS_IDLE   = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    input  logic                        din,
    output logic                        sck,
    output logic                        cs,
    output logic [NUM_CH*ADC_WIDTH-1:0] sample,
    output logic                        sample_valid,
    output logic                        busy
);
    localparam int WORD_BITS  = LEAD_BITS + ADC_WIDTH;
    localparam int TOTAL_BITS = NUM_CH * WORD_BITS;
    localparam int MAX_BITS   = 8 * (LEAD_BITS + 16);
    localparam int DATA_W     = NUM_CH * ADC_WIDTH;
    localparam int BIT_W      = $clog2(MAX_BITS + 1);
    localparam int POS_W      = $clog2(WORD_BITS + 1);
    localparam int DIV_W      = $clog2(CLK_DIV + 1);
    localparam int GAP_W      = $clog2(CS_IDLE + 1);

    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, GAP} state_t;

    state_t               state_reg;
    logic [DIV_W-1:0]     div_reg;
    logic [GAP_W-1:0]     gap_reg;
    logic [BIT_W-1:0]     bit_reg;
    logic [POS_W-1:0]     pos_reg;
    logic [DATA_W-1:0]    shift_reg;
    logic [DATA_W-1:0]    sample_next;
    logic [ADC_WIDTH-1:0] raw_word [NUM_CH];
    logic [ADC_WIDTH-1:0] out_word [NUM_CH];
    logic                 div_hit;
    logic                 gap_hit;
    logic                 last_bit;
    logic                 data_bit;
    logic                 frame_end;

    assign div_hit   = (div_reg == DIV_W'(CLK_DIV - 1));
    assign gap_hit   = (gap_reg == GAP_W'(CS_IDLE - 1));
    assign last_bit  = (bit_reg == BIT_W'(TOTAL_BITS - 1));
    assign data_bit  = (int'(pos_reg) >= LEAD_BITS);
    assign frame_end = (state_reg == SHIFT) && sck && div_hit && last_bit;

    // Data bits of all words share one shift register, so word 0 ends up in the top slice.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            assign raw_word[gi] = shift_reg[(NUM_CH-gi)*ADC_WIDTH-1 -: ADC_WIDTH];
`ifdef ADC_AVG_EN
            logic [ADC_WIDTH-1:0] hist_reg [4];
            logic [ADC_WIDTH+1:0] sum_reg;
            logic [ADC_WIDTH+1:0] sum_next;

            assign sum_next = sum_reg - {2'b00, hist_reg[3]} + {2'b00, raw_word[gi]};

            always_ff @(posedge clk) begin
                if (rst) begin
                    sum_reg <= '0;
                    for (int i = 0; i < 4; i++) begin
                        hist_reg[i] <= '0;
                    end
                end else if (frame_end) begin
                    sum_reg     <= sum_next;
                    hist_reg[0] <= raw_word[gi];
                    for (int i = 1; i < 4; i++) begin
                        hist_reg[i] <= hist_reg[i-1];
                    end
                end
            end

            assign out_word[gi] = sum_next[ADC_WIDTH+1:2];
`else
            assign out_word[gi] = raw_word[gi];
`endif
            assign sample_next[gi*ADC_WIDTH +: ADC_WIDTH] = out_word[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            cs           <= 1'b1;
            sck          <= 1'b0;
            busy         <= 1'b0;
            sample_valid <= 1'b0;
            sample       <= '0;
            shift_reg    <= '0;
            div_reg      <= '0;
            gap_reg      <= '0;
            bit_reg      <= '0;
            pos_reg      <= '0;
        end else begin
            sample_valid <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (en) begin
                        cs        <= 1'b0;
                        busy      <= 1'b1;
                        div_reg   <= '0;
                        bit_reg   <= '0;
                        pos_reg   <= '0;
                        state_reg <= SETUP;
                    end
                end
                SETUP: begin
                    if (div_hit) begin
                        div_reg   <= '0;
                        sck       <= 1'b1;
                        state_reg <= SHIFT;
                        if (data_bit) begin
                            shift_reg <= {shift_reg[DATA_W-2:0], din};
                        end
                    end else begin
                        div_reg <= div_reg + 1'b1;
                    end
                end
                SHIFT: begin
                    if (div_hit) begin
                        div_reg <= '0;
                        if (sck) begin
                            sck <= 1'b0;
                            if (last_bit) begin
                                cs           <= 1'b1;
                                sample       <= sample_next;
                                sample_valid <= 1'b1;
                                gap_reg      <= '0;
                                state_reg    <= GAP;
                            end else begin
                                bit_reg <= bit_reg + 1'b1;
                                pos_reg <= (pos_reg == POS_W'(WORD_BITS - 1)) ? '0 : pos_reg + 1'b1;
                            end
                        end else begin
                            sck <= 1'b1;
                            if (data_bit) begin
                                shift_reg <= {shift_reg[DATA_W-2:0], din};
                            end
                        end
                    end else begin
                        div_reg <= div_reg + 1'b1;
                    end
                end
                GAP: begin
                    if (gap_hit) begin
                        // Back-to-back frames skip IDLE so cs falls exactly CS_IDLE cycles after rising.
                        if (en) begin
                            cs        <= 1'b0;
                            div_reg   <= '0;
                            bit_reg   <= '0;
                            pos_reg   <= '0;
                            state_reg <= SETUP;
                        end else begin
                            busy      <= 1'b0;
                            state_reg <= IDLE;
                        end
                    end else begin
                        gap_reg <= gap_reg + 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_adc_scanner.sv
// Directed bench for spi_adc_scanner: default instance plus a 4x16-bit, no-lead, fast-SCK instance.
`timescale 1ns/1ps
module tb_spi_adc_scanner;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a = 1'b1, en_a = 1'b0, din_a, sck_a, cs_a, valid_a, busy_a;
    logic [23:0] sample_a;
    logic        rst_b = 1'b1, en_b = 1'b0, din_b, sck_b, cs_b, valid_b, busy_b;
    logic [63:0] sample_b;

    spi_adc_scanner dut_a (
        .clk(clk), .rst(rst_a), .en(en_a), .din(din_a), .sck(sck_a), .cs(cs_a),
        .sample(sample_a), .sample_valid(valid_a), .busy(busy_a)
    );

    spi_adc_scanner #(
        .ADC_WIDTH(16), .NUM_CH(4), .LEAD_BITS(0), .CLK_DIV(1), .CS_IDLE(4)
    ) dut_b (
        .clk(clk), .rst(rst_b), .en(en_b), .din(din_b), .sck(sck_b), .cs(cs_b),
        .sample(sample_b), .sample_valid(valid_b), .busy(busy_b)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ADC model: words latched at cs fall, next bit presented after each sck fall, dummy bits driven 1.
    logic [127:0] next_a = '0, cur_a = '0, next_b = '0, cur_b = '0;
    int k_a = 0, k_b = 0;

    always @(negedge cs_a) begin cur_a = next_a; k_a = 0; end
    always @(negedge sck_a) k_a = k_a + 1;
    always @(negedge cs_b) begin cur_b = next_b; k_b = 0; end
    always @(negedge sck_b) k_b = k_b + 1;

    function automatic logic adc_bit(input int k, input logic [127:0] words, input int w,
                                     input int lead, input int nch);
        int wb, word, pos;
        wb = w + lead;
        if (k >= nch * wb) return 1'b0;
        word = k / wb;
        pos  = k % wb;
        if (pos < lead) return 1'b1;
        return words[word*w + w - 1 - (pos - lead)];
    endfunction

    assign din_a = adc_bit(k_a, cur_a, 12, 5, 2);
    assign din_b = adc_bit(k_b, cur_b, 16, 0, 4);

    // Expected output per channel: raw word, or mean of the last 4 frames when averaging is built in.
    int hist_m [2][8][4];

    task automatic model_clear(input int d);
        for (int c = 0; c < 8; c++)
            for (int i = 0; i < 4; i++) hist_m[d][c][i] = 0;
    endtask

    task automatic model_word(input int d, input int c, input int raw, output int exp);
`ifdef ADC_AVG_EN
        int s;
        s = 0;
        for (int i = 3; i > 0; i--) hist_m[d][c][i] = hist_m[d][c][i-1];
        hist_m[d][c][0] = raw;
        for (int i = 0; i < 4; i++) s += hist_m[d][c][i];
        exp = s >> 2;
`else
        hist_m[d][c][0] = raw;
        exp = hist_m[d][c][0];
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_t0_a(input string tag);
        int n;
        n = 0;
        while (cs_a !== 1'b0 && n < 8) begin
            tick();
            n++;
        end
        check({tag, "_t0_latency"}, n, 1);
    endtask

    // Entered at T0 of a default-instance frame; leaves at T0+276.
    task automatic frame_a(input string tag, input int e0, input int e1,
                           input logic [23:0] nxt, input int drop_at);
        int bad_valid, bad_sck, bad_cs;
        logic exp_sck;
        bad_valid = 0; bad_sck = 0; bad_cs = 0;
        for (int n = 1; n < 272; n++) begin
            tick();
            if (n == drop_at) en_a = 1'b0;
            exp_sck = ((n / 4) % 2) == 1;
            if (valid_a !== 1'b0) bad_valid++;
            if (sck_a !== exp_sck) bad_sck++;
            if (cs_a !== 1'b0) bad_cs++;
        end
        check({tag, "_no_early_valid"}, bad_valid, 0);
        check({tag, "_sck_pattern"}, bad_sck, 0);
        check({tag, "_cs_low"}, bad_cs, 0);
        tick();
        check({tag, "_valid"}, valid_a, 1);
        check({tag, "_cs_rise"}, cs_a, 1);
        check({tag, "_sck_idle"}, sck_a, 0);
        check({tag, "_busy_frame"}, busy_a, 1);
        check({tag, "_word0"}, sample_a[11:0], e0);
        check({tag, "_word1"}, sample_a[23:12], e1);
        next_a = {104'b0, nxt};
        tick();
        check({tag, "_valid_width"}, valid_a, 0);
        tick();
        tick();
        check({tag, "_busy_gap"}, busy_a, 1);
        check({tag, "_cs_gap"}, cs_a, 1);
        tick();
        if (en_a) begin
            check({tag, "_restart_cs"}, cs_a, 0);
        end else begin
            check({tag, "_busy_fall"}, busy_a, 0);
            check({tag, "_cs_stay"}, cs_a, 1);
        end
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int e0, e1, bad, n;
        int va [4][2];
        logic [23:0] nxt;
        logic [15:0] bw [4];

        va[0][0] = 100;  va[0][1] = 200;
        va[1][0] = 300;  va[1][1] = 400;
        va[2][0] = 4095; va[2][1] = 0;
        va[3][0] = 1445; va[3][1] = 2650;
        model_clear(0);
        model_clear(1);

        repeat (3) tick();
        check("rst_cs", cs_a, 1);
        check("rst_sck", sck_a, 0);
        check("rst_sample", sample_a, 0);
        check("rst_valid", valid_a, 0);
        check("rst_busy", busy_a, 0);
        check("rst_cs_b", cs_b, 1);
        check("rst_sample_b", sample_b, 0);
        rst_a = 1'b0;
        rst_b = 1'b0;
        tick();
        check("idle_cs", cs_a, 1);

        // Four back-to-back frames; en drops at T0+10 of the last.
        next_a = {104'b0, 12'd200, 12'd100};
        en_a = 1'b1;
        wait_t0_a("f0");
        for (int f = 0; f < 4; f++) begin
            model_word(0, 0, va[f][0], e0);
            model_word(0, 1, va[f][1], e1);
            nxt = (f < 3) ? {12'(va[f+1][1]), 12'(va[f+1][0])} : 24'h0;
            frame_a($sformatf("f%0d", f), e0, e1, nxt, (f == 3) ? 10 : -1);
        end
        bad = 0;
        repeat (20) begin
            tick();
            if (cs_a !== 1'b1 || busy_a !== 1'b0) bad++;
        end
        check("idle_after_drop", bad, 0);

        // Reset at T0+150 discards the frame and clears sample.
        next_a = {104'b0, 12'd456, 12'd123};
        en_a = 1'b1;
        wait_t0_a("rstmid");
        repeat (150) tick();
        rst_a = 1'b1;
        en_a = 1'b0;
        tick();
        check("rstmid_cs", cs_a, 1);
        check("rstmid_sck", sck_a, 0);
        check("rstmid_sample", sample_a, 0);
        check("rstmid_busy", busy_a, 0);
        check("rstmid_valid", valid_a, 0);
        model_clear(0);
        rst_a = 1'b0;
        bad = 0;
        repeat (300) begin
            tick();
            if (valid_a !== 1'b0 || cs_a !== 1'b1) bad++;
        end
        check("rstmid_no_valid", bad, 0);

`ifdef ADC_AVG_EN
        next_a = {104'b0, 12'd400, 12'd400};
        en_a = 1'b1;
        wait_t0_a("avg");
        for (int f = 0; f < 5; f++) begin
            e0 = (f < 3) ? 100 * (f + 1) : 400;
            frame_a($sformatf("avg%0d", f), e0, e0, {12'd400, 12'd400}, (f == 4) ? 10 : -1);
        end
`endif

        // Wide instance: 4 x 16-bit words, no lead bits, CLK_DIV=1.
        bw[0] = 16'hFFFF; bw[1] = 16'h0001; bw[2] = 16'h8000; bw[3] = 16'h1234;
        next_b = {64'b0, bw[3], bw[2], bw[1], bw[0]};
        en_b = 1'b1;
        n = 0;
        while (cs_b !== 1'b0 && n < 8) begin
            tick();
            n++;
        end
        check("b_t0_latency", n, 1);
        bad = 0;
        for (int t = 1; t < 128; t++) begin
            tick();
            if (t == 10) en_b = 1'b0;
            if (valid_b !== 1'b0) bad++;
        end
        check("b_no_early_valid", bad, 0);
        tick();
        check("b_valid", valid_b, 1);
        check("b_cs_rise", cs_b, 1);
        for (int c = 0; c < 4; c++) begin
            model_word(1, c, int'(bw[c]), e0);
            check($sformatf("b_word%0d", c), sample_b[c*16 +: 16], e0);
        end
        tick();
        check("b_valid_width", valid_b, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
